uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// UART receiver bus: serial line in, received byte and status pulses out.
// The receiver sits on the master side; the byte consumer on the slave side.
interface uart_rx_if #(
    parameter int NB_DATA = 8
);
    logic               i_rx;
    logic [NB_DATA-1:0] o_data;
    logic               o_rx_done;
    logic               o_frame_err;

    modport master (
        input  i_rx,
        output o_data,
        output o_rx_done,
        output o_frame_err
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_rx_done,
        input  o_frame_err
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: start-bit centring, LSB-first data,
// stop-bit check with break lockout until the line returns high.
module uart_rx #(
    parameter int NB_DATA    = 8,
    parameter int OVERSAMPLE = 16,
    parameter int NB_STOP    = 16,
    parameter int BAUD_DIV   = 163
) (
    input  logic     clk,
    input  logic     i_rst_n,
    uart_rx_if.master bus
);
    localparam int TMAX = (OVERSAMPLE > NB_STOP) ? OVERSAMPLE : NB_STOP;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
    localparam int DW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] T_BIT  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] T_STOP = TW'(NB_STOP - 1);
    localparam logic [BW-1:0] N_LAST = BW'(NB_DATA - 1);
    localparam logic [DW-1:0] B_LAST = DW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic               rx_meta;
    logic               rx_sync;
    logic [DW-1:0]      baud_cnt;
    logic               tick;
    logic [TW-1:0]      tick_cnt;
    logic [BW-1:0]      bit_cnt;
    logic [NB_DATA-1:0] shreg;
    logic [NB_DATA-1:0] data_q;
    logic               done_q;
    logic               err_q;
    logic               armed;

    assign bus.o_data      = data_q;
    assign bus.o_rx_done   = done_q;
    assign bus.o_frame_err = err_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.i_rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running divider producing one oversampling tick every BAUD_DIV clocks.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            baud_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick <= (baud_cnt == B_LAST);
            if (baud_cnt == B_LAST) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Frame FSM with registered data and one-clock status pulses.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            armed    <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (rx_sync) begin
                armed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_sync && armed) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_cnt == T_MID) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            state    <= rx_sync ? IDLE : DATA;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tick_cnt == T_BIT) begin
                            tick_cnt <= '0;
                            shreg    <= {rx_sync, shreg[NB_DATA-1:1]};
                            if (bit_cnt == N_LAST) begin
                                state <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tick_cnt == T_STOP) begin
                            tick_cnt <= '0;
                            state    <= IDLE;
                            if (rx_sync) begin
                                data_q <= shreg;
                                done_q <= 1'b1;
                            end else begin
                                // Disarm so a held-low break reports only once.
                                err_q <= 1'b1;
                                armed <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
